// File: rtl/round_robin_burst_arbiter_pkg.sv
// Shared state encoding and sizing helper for the round-robin burst arbiter.
package round_robin_burst_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

    // Ceiling log2 that never returns less than 1, so counters and indices keep at least one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/Thermometer_Mask.sv
// Thermometer mask: ones from the lowest set bit of the input upward; all ones when the input is zero.
module Thermometer_Mask #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] onehot_in,
    output logic [WIDTH-1:0] mask_out
);

    logic seen;

    always_comb begin
        seen     = 1'b0;
        mask_out = '1;
        if (|onehot_in) begin
            for (int i = 0; i < WIDTH; i++) begin
                seen        = seen | onehot_in[i];
                mask_out[i] = seen;
            end
        end
    end

endmodule

// File: rtl/lowest_set_bit.sv
// Isolates the lowest set bit of a vector (x & -x); zero in gives zero out.
module lowest_set_bit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] vec_in,
    output logic [WIDTH-1:0] lsb_out
);

    assign lsb_out = vec_in & (~vec_in + WIDTH'(1));

endmodule

// File: rtl/round_robin_burst_arbiter.sv
// Round-robin arbiter with registered one-hot grants and a bounded burst per holder.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | no grant outstanding; next request wins by rotated priority
// ST_HOLD | grant_q owns the resource; burst_count_q counts its cycles
module round_robin_burst_arbiter
    import round_robin_burst_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH = 4,
    parameter int BURST_MAX  = 3
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [WORD_WIDTH-1:0]                requests,
    output logic [WORD_WIDTH-1:0]                grant,
    output logic                                 grant_valid,
    output logic [clog2_min1(WORD_WIDTH)-1:0]    grant_index
);

    localparam int IDX_W = clog2_min1(WORD_WIDTH);
    localparam int CNT_W = clog2_min1(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    arb_state_e              state_q, state_d;
    logic [WORD_WIDTH-1:0]   grant_q, grant_d;
    logic [WORD_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic                    grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]        grant_index_q, grant_index_d;
    logic [CNT_W-1:0]        burst_count_q, burst_count_d;

    logic [WORD_WIDTH-1:0]   therm_mask;
    logic [WORD_WIDTH-1:0]   prio_mask;
    logic [WORD_WIDTH-1:0]   masked_req;
    logic [WORD_WIDTH-1:0]   cand_masked;
    logic [WORD_WIDTH-1:0]   cand_any;
    logic [WORD_WIDTH-1:0]   cand;
    logic                    holder_req;
    logic                    others_pending;
    logic                    burst_open;

    Thermometer_Mask #(.WIDTH(WORD_WIDTH)) u_therm (
        .onehot_in (last_grant_q),
        .mask_out  (therm_mask)
    );

    // Only bits strictly above the last winner get first pick; the unmasked search handles wrap-around.
    assign prio_mask  = therm_mask & ~last_grant_q;
    assign masked_req = requests & prio_mask;

    lowest_set_bit #(.WIDTH(WORD_WIDTH)) u_lsb_masked (
        .vec_in  (masked_req),
        .lsb_out (cand_masked)
    );

    lowest_set_bit #(.WIDTH(WORD_WIDTH)) u_lsb_any (
        .vec_in  (requests),
        .lsb_out (cand_any)
    );

    assign cand           = (|masked_req) ? cand_masked : cand_any;
    assign holder_req     = |(requests & grant_q);
    assign others_pending = |(requests & ~grant_q);
    assign burst_open     = (BURST_MAX == 0) || (burst_count_q < BURST_LIMIT);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        burst_count_d = burst_count_q;

        if (state_q == ST_IDLE) begin
            if (|requests) begin
                state_d       = ST_HOLD;
                grant_d       = cand;
                burst_count_d = CNT_ONE;
            end
        end else begin
            if (!holder_req) begin
                if (others_pending) begin
                    grant_d       = cand;
                    burst_count_d = CNT_ONE;
                end else begin
                    state_d       = ST_IDLE;
                    grant_d       = '0;
                    burst_count_d = '0;
                end
            end else if (burst_open) begin
                if (BURST_MAX != 0) begin
                    burst_count_d = burst_count_q + CNT_ONE;
                end
            end else if (others_pending) begin
                // The holder sits at the bottom of the rotated priority, so cand is always someone else.
                grant_d       = cand;
                burst_count_d = CNT_ONE;
            end
        end

        last_grant_d  = (|grant_d) ? grant_d : last_grant_q;
        grant_valid_d = |grant_d;

        grant_index_d = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (grant_d[i]) begin
                grant_index_d = grant_index_d | IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            last_grant_q  <= '0;
            grant_valid_q <= 1'b0;
            grant_index_q <= '0;
            burst_count_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            grant_valid_q <= grant_valid_d;
            grant_index_q <= grant_index_d;
            burst_count_q <= burst_count_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_index = grant_index_q;

endmodule

// File: tb/tb_round_robin_burst_arbiter.sv
// Self-checking bench for round_robin_burst_arbiter: directed scenarios plus a randomized run against a rotation model.
module tb_round_robin_burst_arbiter;

    localparam int N          = 4;
    localparam int BM         = 3;
    localparam int WAIT_LIMIT = (N - 1) * BM + 1;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] requests = '0;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_index;

    int checks = 0;
    int errors = 0;

    round_robin_burst_arbiter #(
        .WORD_WIDTH (N),
        .BURST_MAX  (BM)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .requests    (requests),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_index (grant_index)
    );

    always #5 clock = ~clock;

    task automatic do_reset();
        reset    = 1'b1;
        requests = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic step(input logic [N-1:0] r);
        requests = r;
        @(posedge clock);
        #1;
    endtask

    // First requester at or after position p in circular order; -1 if nobody requests.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step(4'b0000);
            checks++;
            if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_index !== 2'd0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got grant=%b valid=%b idx=%0d, want 0000/0/0",
                         c, grant, grant_valid, grant_index);
            end
        end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step(4'b0000);
            checks++;
            if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_index !== 2'd0) begin
                errors++;
                $display("FAIL idle_no_req cycle %0d: got grant=%b valid=%b idx=%0d, want 0000/0/0",
                         c, grant, grant_valid, grant_index);
            end
        end
    endtask

    task automatic test_all_request();
        logic [N-1:0] exp_g;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            step(4'b1111);
            exp_g = 4'(1 << ((c / 3) % N));
            checks++;
            if (grant !== exp_g || grant_valid !== 1'b1 || grant_index !== 2'((c / 3) % N)) begin
                errors++;
                $display("FAIL all_request cycle %0d: got grant=%b valid=%b idx=%0d, want %b/1/%0d",
                         c, grant, grant_valid, grant_index, exp_g, (c / 3) % N);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            step(4'b0100);
            checks++;
            if (grant !== 4'b0100 || grant_valid !== 1'b1 || grant_index !== 2'd2) begin
                errors++;
                $display("FAIL single_req cycle %0d: got grant=%b valid=%b idx=%0d, want 0100/1/2",
                         c, grant, grant_valid, grant_index);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] stim [3];
        logic [N-1:0] want [3];
        stim[0] = 4'b0010; want[0] = 4'b0010;
        stim[1] = 4'b1001; want[1] = 4'b1000;
        stim[2] = 4'b0001; want[2] = 4'b0001;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            step(stim[c]);
            checks++;
            if (grant !== want[c] || grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back step %0d: got grant=%b valid=%b, want %b/1",
                         c, grant, grant_valid, want[c]);
            end
        end
    endtask

    task automatic test_preempt();
        do_reset();
        for (int c = 0; c < 4; c++) step(4'b0001);
        step(4'b0101);
        checks++;
        if (grant !== 4'b0100 || grant_index !== 2'd2) begin
            errors++;
            $display("FAIL preempt: got grant=%b idx=%0d, want 0100/2", grant, grant_index);
        end
        // With last_grant at bit 2, bit 3 outranks bit 1.
        step(4'b1011);
        checks++;
        if (grant !== 4'b1000) begin
            errors++;
            $display("FAIL preempt_last_grant: got grant=%b, want 1000", grant);
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        for (int c = 0; c < 8; c++) step(4'b1111);
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL mid_hold_setup: got grant=%b, want 0100", grant);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_index !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: got grant=%b valid=%b idx=%0d, want 0000/0/0",
                     grant, grant_valid, grant_index);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(4'b1111);
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL restart_after_reset: got grant=%b, want 0001", grant);
        end
    endtask

    task automatic test_random(input int ncyc);
        int           holder;
        int           cnt;
        int           ptr;
        int           waitc [N];
        int           worst;
        logic [N-1:0] r;
        logic [N-1:0] exp_g;
        holder = -1;
        cnt    = 0;
        ptr    = 0;
        r      = '0;
        for (int i = 0; i < N; i++) waitc[i] = 0;
        do_reset();
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(3) == 0) r[i] = ~r[i];
            end
            requests = r;
            @(posedge clock);

            if (holder < 0 || !r[holder]) begin
                holder = pick(r, ptr);
                cnt    = 1;
                if (holder >= 0) ptr = (holder + 1) % N;
            end else if (cnt < BM) begin
                cnt = cnt + 1;
            end else if ((r & ~(4'(1 << holder))) != 0) begin
                holder = pick(r, ptr);
                cnt    = 1;
                ptr    = (holder + 1) % N;
            end
            #1;

            exp_g = (holder >= 0) ? 4'(1 << holder) : 4'b0000;
            checks++;
            if (grant !== exp_g) begin
                errors++;
                $display("FAIL rand_grant cycle %0d req=%b: got %b, want %b", cyc, r, grant, exp_g);
            end
            checks++;
            if (grant_valid !== (holder >= 0)) begin
                errors++;
                $display("FAIL rand_valid cycle %0d: got %b, want %b", cyc, grant_valid, holder >= 0);
            end
            checks++;
            if (grant_index !== ((holder >= 0) ? 2'(holder) : 2'd0)) begin
                errors++;
                $display("FAIL rand_index cycle %0d: got %0d, want %0d", cyc, grant_index,
                         (holder >= 0) ? holder : 0);
            end
            checks++;
            if (!(grant == '0 || $onehot(grant)) || (grant & ~r) != '0) begin
                errors++;
                $display("FAIL rand_onehot_req cycle %0d: got grant=%b with req=%b, want one-hot subset",
                         cyc, grant, r);
            end
            worst = 0;
            for (int i = 0; i < N; i++) begin
                if (r[i] && !grant[i]) waitc[i] = waitc[i] + 1;
                else                   waitc[i] = 0;
                if (waitc[i] > worst) worst = waitc[i];
            end
            checks++;
            if (worst > WAIT_LIMIT) begin
                errors++;
                $display("FAIL rand_starve cycle %0d: wait %0d cycles, limit %0d", cyc, worst, WAIT_LIMIT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_request();
        test_single();
        test_back_to_back();
        test_preempt();
        test_reset_mid_hold();
        test_random(10000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
